// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared constants and index helpers for the round-robin stream mux.
package rr_stream_mux_pkg;

  localparam int MAX_IN = 256;
  localparam int RST_PTR = 0;

  function automatic int unsigned onehot_idx(input logic [MAX_IN-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_IN; i++)
      if (oh[i]) idx = idx | int'(i);
    return idx;
  endfunction

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant over req; RR_STREAM_MUX_FIXED_PRIO_EN selects fixed lowest-index priority.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [NUM_IN-1:0] pick;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst, advance};
  always_comb pick = req;
`else
  logic [SEL_W-1:0]  ptr;
  logic [NUM_IN-1:0] masked;
  // requests at or above ptr win; otherwise wrap to the lowest request
  always_comb begin
    masked = req & ({NUM_IN{1'b1}} << ptr);
    pick = |masked ? masked : req;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= SEL_W'(RST_PTR);
    else if (advance) ptr <= SEL_W'(next_idx(int'(grant_idx), NUM_IN));
`endif

  always_comb begin
    grant = pick & (~pick + NUM_IN'(1));
    grant_idx = SEL_W'(onehot_idx(MAX_IN'(grant)));
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream mux with round-robin arbitration and one registered output stage.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              can_load;
  logic              take;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(in_valid),
    .advance(take),
    .grant(grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    can_load = ~out_valid | out_ready;
    in_ready = grant & {NUM_IN{can_load & ~rst}};
    take = can_load & ~rst & (|grant);
  end

  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data <= in_data[grant_idx*WIDTH +: WIDTH];
      out_sel <= grant_idx;
    end else if (out_ready) out_valid <= 1'b0;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed plan plus randomized traffic against a behavioural reference model.
module tb_rr_stream_mux;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready = 1'b0;

  logic         rst3 = 1'b1;
  logic [95:0]  in_data3 = '0;
  logic [2:0]   in_valid3 = '0;
  logic [2:0]   in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;
  logic         out_ready3 = 1'b0;

  int errors = 0;
  int checks = 0;

  int          mptr = 0;
  logic        mv = 1'b0;
  logic [31:0] md = '0;
  int          ms = 0;
  logic [3:0]  last_ready;

  logic         rule_on = 1'b0;
  logic         prev_on = 1'b0;
  logic [3:0]   prev_v, prev_r;
  logic [127:0] prev_d;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_stream_mux #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  // unaccepted offers must be held unchanged by the producer
  always @(posedge clk) begin
    if (rule_on && prev_on)
      for (int i = 0; i < 4; i++)
        if (prev_v[i] && !prev_r[i])
          assert (in_valid[i] && in_data[i*32 +: 32] == prev_d[i*32 +: 32])
            else $error("producer rule broken on channel %0d", i);
    prev_on <= rule_on;
    prev_v <= in_valid;
    prev_r <= in_ready;
    prev_d <= in_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic step(input logic r, input logic [3:0] v, input logic [127:0] d, input logic ordy);
    int g;
    logic take;
    logic [3:0] er;
    rst = r;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    #1;
    g = pick(v, mptr);
    take = !r && g >= 0 && (!mv || ordy);
    er = take ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", in_ready, er);
    last_ready = in_ready;
    @(posedge clk);
    #1;
    if (r) begin
      mv = 1'b0; md = '0; ms = 0; mptr = 0;
    end else if (take) begin
      mv = 1'b1; md = d[g*32 +: 32]; ms = g;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
      mptr = (g + 1) % 4;
`endif
    end else if (ordy) mv = 1'b0;
    chk("out_valid", out_valid, mv);
    if (mv || r) begin
      chk("out_data", out_data, md);
      chk("out_sel", out_sel, ms);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] d;
    logic [3:0] pv;
    logic [31:0] pd [4];
    int e;
    @(negedge clk);
    // reset and idle
    step(1, 4'b0000, '0, 1);
    step(1, 4'b0000, '0, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_ready", last_ready, 0);
    // single channel
    d = '0; d[64 +: 32] = 32'hDEADBEEF;
    step(0, 4'b0100, d, 1);
    chk("single_ready", last_ready, 4'b0100);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_sel", out_sel, 2);
    chk("single_valid", out_valid, 1);
    step(0, 4'b0000, d, 1);
    chk("drain_valid", out_valid, 0);
    // all channels streaming
    step(1, 4'b0000, '0, 1);
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'h100 + i;
    for (int k = 0; k < 6; k++) begin
      step(0, 4'b1111, d, 1);
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 4;
`endif
      chk("rr_sel", out_sel, e);
      chk("rr_valid", out_valid, 1);
      chk("rr_data", out_data, 32'h100 + e);
    end
    // back-pressure
    step(1, 4'b0000, '0, 1);
    d = '0; d[32 +: 32] = 32'hA5A5A5A5;
    step(0, 4'b0010, d, 1);
    d = '0; d[0 +: 32] = 32'h1000; d[96 +: 32] = 32'h3333;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b1001, d, 0);
      chk("bp_ready", last_ready, 0);
      chk("bp_data", out_data, 32'hA5A5A5A5);
      chk("bp_sel", out_sel, 1);
      chk("bp_valid", out_valid, 1);
    end
    step(0, 4'b1001, d, 1);
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
    chk("bp_release_sel", out_sel, 0);
`else
    chk("bp_release_sel", out_sel, 3);
`endif
    // reset mid-stream
    d = '0; d[0 +: 32] = 32'h12345678;
    step(0, 4'b0001, d, 1);
    chk("mid_data", out_data, 32'h12345678);
    step(1, 4'b1000, d, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    d = '0; d[32 +: 32] = 32'h11; d[96 +: 32] = 32'h33;
    step(0, 4'b1010, d, 1);
    chk("post_rst_sel", out_sel, 1);
    // randomized traffic
    step(1, 4'b0000, '0, 1);
    pv = '0;
    rule_on = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pd[i] = $urandom;
        end
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = pd[i];
      step($urandom_range(0, 49) == 0, pv, d, $urandom_range(0, 3) != 0);
      pv = pv & ~last_ready;
    end
    rule_on = 1'b0;
    // three-channel wrap
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    in_valid3 = 3'b111;
    out_ready3 = 1'b1;
    in_data3 = {32'h202, 32'h201, 32'h200};
    for (int k = 0; k < 4; k++) begin
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 3;
`endif
      #1;
      chk("n3_ready", in_ready3, 3'b001 << e);
      @(posedge clk);
      #1;
      chk("n3_sel", out_sel3, e);
      chk("n3_data", out_data3, 32'h200 + e);
      chk("n3_valid", out_valid3, 1);
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
